// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART block family (transmitter, receiver and
// the transmit feeder).
//   DBIT_DEFAULT   : default data byte width used by every UART instance
//   ADDR_W_DEFAULT : default FIFO address width (depth = 2**ADDR_W_DEFAULT)
//   feeder_state_t : launch controller states of uart_tx_feeder
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DBIT_DEFAULT   = 8;
  localparam int ADDR_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock circular FIFO with occupancy count, flush and overflow flag.
//   clk, reset : system clock, synchronous active-high reset
//   wr_en      : enqueue wr_data on this edge when not full
//   wr_data    : byte to enqueue
//   rd_en      : pop the head on this edge when not empty
//   flush      : clear pointers and count on this edge (beats write and pop)
//   rd_data    : current head of the FIFO (valid when !empty)
//   full       : count == 2**ADDR_W
//   empty      : count == 0
//   count      : occupancy, 0..2**ADDR_W
//   overflow   : one-cycle pulse after a write attempt while full
// ---------------------------------------------------------------------------
module sync_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DBIT   = DBIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DBIT-1:0]   wr_data,
  input  logic              rd_en,
  input  logic              flush,
  output logic [DBIT-1:0]   rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [DBIT-1:0]   mem_q [DEPTH];
  logic [DBIT-1:0]   mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              wr_accept;
  logic              rd_accept;

  // Flags decode the registered count, so acceptance never depends on the
  // same-cycle request; pointers wrap naturally and count tells full from empty.
  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign overflow = overflow_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and count. Flush wins over everything
  // and silently drops a same-cycle write (no overflow either).
  always_comb begin
    wr_accept  = wr_en && !full && !flush;
    rd_accept  = rd_en && !empty && !flush;
    overflow_d = wr_en && full && !flush;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
// Byte buffer and launch controller in front of the UART transmitter. Bytes
// from the producer are queued in a sync_fifo and launched one at a time:
// a one-cycle tx_start with the byte on tx_din, then wait for tx_done_tick.
//   clk, reset   : system clock, synchronous active-high reset
//   wr_en        : enqueue wr_data when not full
//   wr_data      : byte from the producer
//   flush        : clear the queue; a byte already launched still completes
//   tx_done_tick : transmitter finished its stop bit
//   tx_start     : one-cycle launch pulse to the transmitter
//   tx_din       : byte being transmitted, held until tx_done_tick
//   full, empty  : FIFO occupancy flags
//   count        : FIFO occupancy, 0..2**ADDR_W
//   busy         : a byte is being launched or transmitted
//   overflow     : one-cycle pulse after a write was dropped because full
// ---------------------------------------------------------------------------
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DBIT   = DBIT_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DBIT-1:0]   wr_data,
  input  logic              flush,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow
);

  feeder_state_t   state_q, state_d;
  logic            tx_start_q, tx_start_d;
  logic [DBIT-1:0] tx_din_q, tx_din_d;
  logic            pop;
  logic [DBIT-1:0] fifo_head;

  sync_fifo #(
    .ADDR_W (ADDR_W),
    .DBIT   (DBIT)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .flush    (flush),
    .rd_data  (fifo_head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
  assign busy     = (state_q != IDLE);

  // Launch sequencing. The pop is suppressed during flush because the FIFO
  // ignores it then; launching anyway would send a stale head byte.
  // tx_start is registered so it is high exactly while the state is LAUNCH.
  always_comb begin
    state_d    = state_q;
    tx_din_d   = tx_din_q;
    tx_start_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !flush) begin
          pop        = 1'b1;
          tx_din_d   = fifo_head;
          tx_start_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (tx_done_tick) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_din_q   <= tx_din_d;
    end
  end

endmodule
